// File: rtl/consumer_fetch_pkg.sv
// -----------------------------------------------------------------------------
// consumer_fetch_pkg
// Shared types and helpers for the consumer fetch path: FSM state encoding,
// pointer type, element-to-byte shift and the ring-pointer increment.
// -----------------------------------------------------------------------------
package consumer_fetch_pkg;

  localparam int PTR_WIDTH  = 16;
  // One element is one 64-bit word, so element index -> byte offset is << 3.
  localparam int ELEM_SHIFT = 3;

  typedef logic [PTR_WIDTH-1:0] ptr_t;

  typedef logic [1:0] state_t;
  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_REQ  = 2'd1;
  localparam state_t S_WAIT = 2'd2;

  // Advance a ring pointer, wrapping from fifo_len-1 back to 0.
  function automatic ptr_t ptr_incr(input ptr_t p, input ptr_t len);
    return (p == len - 1'b1) ? '0 : p + 1'b1;
  endfunction

endpackage

// File: rtl/fifo_config_pkg.sv
// -----------------------------------------------------------------------------
// fifo_config_pkg
// Configuration record shared by the producer and consumer paths of the
// memory-resident circular FIFO.
//   base_addr : physical byte address of element 0
//   fifo_len  : number of elements in the ring (>= 2)
// -----------------------------------------------------------------------------
package fifo_config_pkg;

  localparam int CFG_ADDR_W = 40;
  localparam int CFG_PTR_W  = 16;

  typedef struct packed {
    logic [CFG_ADDR_W-1:0] base_addr;
    logic [CFG_PTR_W-1:0]  fifo_len;
  } fifo_config_t;

endpackage

// File: rtl/consumer_fetch_unit_if.sv
// -----------------------------------------------------------------------------
// consumer_fetch_unit_if
// Bundles the tri load bus (request + response) and the accelerator-facing
// valid/ready data stream of the consumer fetch unit.
//   master : the fetch unit side (drives requests and the data stream)
//   slave  : the environment side (tri fabric and accelerator)
// -----------------------------------------------------------------------------
interface consumer_fetch_unit_if #(
  parameter int ADDR_W = 40,
  parameter int DATA_W = 64
);

  logic              tri_req_valid;
  logic              tri_req_ready;
  logic [ADDR_W-1:0] tri_req_addr;
  logic              tri_resp_valid;
  logic [DATA_W-1:0] tri_resp_data;
  logic              consumer_data_valid;
  logic              consumer_data_ready;
  logic [DATA_W-1:0] consumer_data;

  modport master (
    output tri_req_valid, tri_req_addr, consumer_data_valid, consumer_data,
    input  tri_req_ready, tri_resp_valid, tri_resp_data, consumer_data_ready
  );

  modport slave (
    input  tri_req_valid, tri_req_addr, consumer_data_valid, consumer_data,
    output tri_req_ready, tri_resp_valid, tri_resp_data, consumer_data_ready
  );

endinterface

// File: rtl/consumer_resp_buffer.sv
// -----------------------------------------------------------------------------
// consumer_resp_buffer
// Small synchronous FIFO holding load responses until the accelerator takes
// them. DEPTH must be a power of two so the indices wrap naturally.
//   clk, rst_n : clock, asynchronous active-low reset
//   push       : write push_data at the tail (never issued when full)
//   pop        : remove the head entry (ignored when empty)
//   pop_data   : head entry, forced to 0 while empty
//   occupancy  : number of stored entries, 0..DEPTH
//   full/empty : occupancy == DEPTH / occupancy == 0
// -----------------------------------------------------------------------------
module consumer_resp_buffer #(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  output logic [DATA_W-1:0]        pop_data,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     full,
  output logic                     empty
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [IDX_W-1:0]  wr_idx;
  logic [IDX_W-1:0]  rd_idx;
  logic [CNT_W-1:0]  count;
  logic              pop_ok;

  assign pop_ok    = pop && !empty;
  assign full      = (count == CNT_W'(DEPTH));
  assign empty     = (count == '0);
  assign occupancy = count;
  // Stale storage is never exposed: the output reads 0 whenever empty.
  assign pop_data  = empty ? '0 : mem[rd_idx];

  // NOTE: the data array has no reset; only the indices and count need one,
  // since an entry is never read before it has been written.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_idx] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_idx <= '0;
      rd_idx <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_idx <= wr_idx + 1'b1;
      end
      if (pop_ok) begin
        rd_idx <= rd_idx + 1'b1;
      end
      case ({push, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // The fetch unit's credit check makes an overflowing write impossible.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && full));

endmodule

// File: rtl/consumer_fetch_unit.sv
// -----------------------------------------------------------------------------
// consumer_fetch_unit
// Read side of the memory-resident circular FIFO. Issues one tri load at a
// time for elements between fetch_ptr and the producer's tail pointer, buffers
// the returned words and streams them to the accelerator. The published head
// pointer only advances when the accelerator accepts a word, so the producer
// can never overwrite an unconsumed slot.
//   clk, rst_n          : clock, asynchronous active-low reset
//   fifo_config_r       : ring base address and length (stable while enabled)
//   enable_i            : permits new loads
//   tail_ptr_i          : producer tail pointer
//   bus                 : tri request/response and accelerator data stream
//   consumer_head_ptr_o : index of the next element the accelerator consumes
// -----------------------------------------------------------------------------
module consumer_fetch_unit
  import consumer_fetch_pkg::*;
#(
  parameter int ADDR_W    = 40,
  parameter int DATA_W    = 64,
  parameter int PTR_W     = 16,
  parameter int BUF_DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  fifo_config_pkg::fifo_config_t fifo_config_r,
  input  logic                         enable_i,
  input  logic [PTR_W-1:0]             tail_ptr_i,
  consumer_fetch_unit_if.master        bus,
  output logic [PTR_W-1:0]             consumer_head_ptr_o
);

  localparam int CNT_W = $clog2(BUF_DEPTH) + 1;

  state_t            state;
  logic [PTR_W-1:0]  fetch_ptr;
  logic [PTR_W-1:0]  head_ptr;
  logic [ADDR_W-1:0] req_addr;

  logic [ADDR_W-1:0] base_addr;
  logic [PTR_W-1:0]  fifo_len;

  logic              non_empty;
  logic              outstanding;
  logic [CNT_W:0]    credit_sum;
  logic              credit;
  logic              issue;
  logic              buf_push;
  logic              buf_pop;
  logic [CNT_W-1:0]  buf_occupancy;
  logic              buf_full;
  logic              buf_empty;
  logic [DATA_W-1:0] buf_data;

  assign base_addr = fifo_config_r.base_addr[ADDR_W-1:0];
  assign fifo_len  = fifo_config_r.fifo_len[PTR_W-1:0];

  // A load is outstanding from the IDLE->REQ transition until its response.
  assign non_empty   = (fetch_ptr != tail_ptr_i);
  assign outstanding = (state != S_IDLE);
  assign credit_sum  = {1'b0, buf_occupancy} + (CNT_W+1)'(outstanding);
  assign credit      = (credit_sum < (CNT_W+1)'(BUF_DEPTH));
  assign issue       = (state == S_IDLE) && enable_i && non_empty && credit;

  // Responses are only accepted while a load is pending; anything arriving in
  // IDLE (e.g. left over from before a reset) is dropped.
  assign buf_push = (state == S_WAIT) && bus.tri_resp_valid;
  assign buf_pop  = bus.consumer_data_valid && bus.consumer_data_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      fetch_ptr <= '0;
      head_ptr  <= '0;
      req_addr  <= '0;
    end else begin
      // NOTE: all state here uses non-blocking assignments so every register
      // sees the pre-edge values of the others, independent of statement order.
      case (state)
        S_IDLE: begin
          if (issue) begin
            // Carry out of ADDR_W is intentionally dropped.
            req_addr <= base_addr + (ADDR_W'(fetch_ptr) << ELEM_SHIFT);
            state    <= S_REQ;
          end
        end
        S_REQ: begin
          // Request stays up regardless of enable_i until the fabric takes it.
          if (bus.tri_req_ready) begin
            fetch_ptr <= ptr_incr(fetch_ptr, fifo_len);
            state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.tri_resp_valid) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase

      if (buf_pop) begin
        head_ptr <= ptr_incr(head_ptr, fifo_len);
      end
    end
  end

  consumer_resp_buffer #(
    .DEPTH  (BUF_DEPTH),
    .DATA_W (DATA_W)
  ) u_resp_buffer (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (buf_push),
    .push_data (bus.tri_resp_data),
    .pop       (buf_pop),
    .pop_data  (buf_data),
    .occupancy (buf_occupancy),
    .full      (buf_full),
    .empty     (buf_empty)
  );

  assign bus.tri_req_valid       = (state == S_REQ);
  assign bus.tri_req_addr        = req_addr;
  assign bus.consumer_data_valid = !buf_empty;
  assign bus.consumer_data       = buf_data;
  assign consumer_head_ptr_o     = head_ptr;

  // Credit accounting guarantees the buffer never fills past capacity.
  a_credit_ok: assert property (@(posedge clk) disable iff (!rst_n) !(buf_push && buf_full));

endmodule
